// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 2;

    // Channel-select width; a single channel still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic legal_div(input logic [31:0] val);
        return val != 32'd0;
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, active/staged divisor, and
// registered tick / divided-clock / ack outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_tick,
    output logic             o_clk,
    output logic             o_pend,
    output logic             o_ack
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_stage;
    logic             r_pend;
    logic             r_tick;
    logic             r_clk;
    logic             r_ack;

    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_clk_next;

    assign w_wrap     = i_en && (r_cnt == (r_div - CNT_W'(1)));
    assign w_cnt_next = w_wrap ? '0 : (r_cnt + CNT_W'(1));
    assign w_clk_next = (r_cnt < (r_div >> 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_div   <= CNT_W'(DEFAULT_DIV);
            r_stage <= CNT_W'(DEFAULT_DIV);
            r_pend  <= 1'b0;
            r_tick  <= 1'b0;
            r_clk   <= 1'b0;
            r_ack   <= 1'b0;
        end else if (i_sync) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
            r_ack  <= 1'b0;
            // A write arriving with sync bypasses staging and applies at once.
            if (i_wr) begin
                r_div  <= i_val;
                r_pend <= 1'b0;
                r_ack  <= 1'b1;
            end else if (r_pend) begin
                r_div  <= r_stage;
                r_pend <= 1'b0;
                r_ack  <= 1'b1;
            end
        end else begin
            r_ack  <= 1'b0;
            r_tick <= 1'b0;
            if (i_en) begin
                r_cnt  <= w_cnt_next;
                r_tick <= w_wrap;
                r_clk  <= w_clk_next;
            end
            if (w_wrap && r_pend) begin
                r_div  <= r_stage;
                r_pend <= 1'b0;
                r_ack  <= 1'b1;
            end
            // Placed last so a write on the wrap cycle re-arms pend after the old value applies.
            if (i_wr) begin
                r_stage <= i_val;
                r_pend  <= 1'b1;
            end
        end
    end

    assign o_tick = r_tick;
    assign o_clk  = r_clk;
    assign o_pend = r_pend;
    assign o_ack  = r_ack;
endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable / divided-clock generator: write decode, error
// flag and sync/reset broadcast around NUM_CH independent channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int SEL_W      = sel_width(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              sync,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] div_ack,
    output logic              div_err
);
    logic              w_sel_ok;
    logic              w_val_ok;
    logic              w_wr_ok;
    logic [NUM_CH-1:0] w_wr_ch;
    logic              r_err;

    assign w_sel_ok = ({{(32-SEL_W){1'b0}}, div_sel} < 32'(NUM_CH));
    assign w_val_ok = legal_div(32'(div_val));
    assign w_wr_ok  = div_wr && w_sel_ok && w_val_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= div_wr && !(w_sel_ok && w_val_ok);
        end
    end

    assign div_err = r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign w_wr_ch[gi] = w_wr_ok && (div_sel == SEL_W'(gi));

            clk_div_chan #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clock  (clock),
                .reset  (reset),
                .i_en   (en[gi]),
                .i_sync (sync),
                .i_wr   (w_wr_ch[gi]),
                .i_val  (div_val),
                .o_tick (tick[gi]),
                .o_clk  (clk_out[gi]),
                .o_pend (pend[gi]),
                .o_ack  (div_ack[gi])
            );
        end
    endgenerate
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parameterised multi-channel clock-enable and divided-clock generator. It replaces fixed divide-by-2 and divide-by-4 dividers with NUM_CH independent channels, each with a runtime-programmable divisor. Each channel produces a one-cycle tick (clock enable) and a divided square-ish clock. Divisor changes are glitch-free, and a sync input re-phases all channels. It sits at the top level, driving the processor, regfile and memory enable domains from the single master clock.

Parameters:
NUM_CH, 4, number of independent divider channels (>=1)
CNT_W, 8, divisor/counter width; legal divisor range 1..2^CNT_W-1
DEFAULT_DIV, 2, divisor loaded into every channel on reset (1..2^CNT_W-1)

Ports:
clock  in  1  master clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
div_wr  in  1  one-cycle strobe: stage div_val for channel div_sel
div_sel  in  $clog2(NUM_CH) (min 1)  target channel of div_wr
div_val  in  CNT_W  new divisor
sync  in  1  realign all channels to count 0
en  in  NUM_CH  per-channel run enable
tick  out  NUM_CH  one-cycle pulse once per divisor period
clk_out  out  NUM_CH  divided clock, period = divisor cycles
pend  out  NUM_CH  staged divisor waiting to be applied
div_ack  out  NUM_CH  one-cycle pulse when a staged divisor takes effect
div_err  out  1  one-cycle pulse: illegal write dropped

Behaviour:
- Reset (clock-synchronous, active-high, overrides everything):
  - cnt=0 and D=DEFAULT_DIV in every channel.
  - pend, tick, clk_out, div_ack and div_err are all 0 the cycle after reset is sampled.
  - Reset mid-period discards staged values.
- Per-channel state:
  - cnt (CNT_W), active divisor D, staged divisor S, pend flag.
- Enabled cycle (en[i]=1, no sync):
  - cnt <= (cnt==D-1) ? 0 : cnt+1
  - tick[i] <= (cnt==D-1)
  - clk_out[i] <= (cnt < D>>1)
  - Outputs are registered, with 1-cycle latency from the counter state.
- Resulting waveforms:
  - D=1: tick stays high, clk_out stays 0.
  - D=2: 50% clock.
  - Odd D: high for floor(D/2) cycles, low for ceil(D/2) cycles.
- Disabled (en[i]=0):
  - cnt, D and clk_out hold; tick=0.
  - A pending divisor still waits for a wrap.
- Write (div_wr=1):
  - div_val=0 or div_sel>=NUM_CH: write dropped, div_err=1 next cycle, state unchanged.
  - Otherwise S[sel]<=div_val and pend[sel]<=1.
  - Write to an already-pending channel: last write wins, exactly one ack is generated.
- Apply:
  - On an enabled cycle with cnt==D-1 and pend=1: D<=S, cnt<=0, pend<=0, div_ack[i]=1 next cycle.
  - The tick for the completing period is still emitted, so there is no runt or lost period.
- Write landing on the wrap cycle of the same channel:
  - The old S (if pending) applies.
  - The new value becomes pending.
- sync=1 (all channels, regardless of en):
  - cnt<=0, tick<=0, clk_out<=0.
  - Any pend applies immediately (D<=S, div_ack pulse).
  - sync and div_wr in the same cycle to channel k: div_val applies immediately to k, pend[k]=0.
  - Following cycles: all enabled channels run phase-aligned from count 0.
- No combinational path from any input to any output.

Decomposition:
- Package clk_div_pkg:
  - CNT_W and DEFAULT_DIV defaults.
  - SEL_W = max(1, $clog2(NUM_CH)).
  - Function legal_div(val) returning val != 0.
- Sub-module clk_div_chan:
  - One channel: cnt, D, S, pend, tick, clk_out, ack.
  - Instantiated NUM_CH times via generate.
- Top level owns:
  - Write decode.
  - div_err register.
  - Broadcast of sync/reset.

Test Plan:
1. Reset 3 cycles, then en=4'hF, DEFAULT_DIV=2 -> every tick[i] pulses on cycles 3,5,7,…; clk_out[i] = 0,1,0,1 starting cycle 1; pend=0.
2. Mid-period div_wr sel=1 val=5 -> pend[1]=1 next cycle. Current period ends with a normal tick and div_ack[1]. Then tick[1] every 5 cycles, clk_out[1] high 2 / low 3. Other channels unaffected.
3. Two writes to ch2 (val=3, then val=6) before its wrap -> single div_ack[2]; period becomes 6; value 3 never observed.
4. div_wr val=0 -> div_err pulse 1 cycle; pend and D unchanged. With NUM_CH=3, sel=3 -> div_err as well.
5. Channels at differing phases, ch0 pending val=7, sync with div_wr sel=3 val=4 -> next cycle all cnt=0 and tick=0; div_ack[0] and div_ack[3] pulse; ticks realign with periods 7/2/2/4.
6. en[3]=0 for 7 cycles mid-count -> tick[3]=0 and clk_out[3] held; resumes at the same count. Reset asserted with pend[1]=1 -> pend cleared, all D=2, no div_ack.
